// File: rtl/game_pkg.sv
// Shared game definitions: game modes, scheduler states, screen geometry
// and the vertical placement rule for newly spawned obstacles.
package game_pkg;

    typedef enum logic [1:0] {
        INITIAL = 2'b00,
        INGAME  = 2'b01,
        PAUSED  = 2'b10,
        ENDED   = 2'b11
    } gamemode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SCROLL = 2'b01,
        SPAWN  = 2'b10
    } sched_state_t;

    localparam int NUM_OBS        = 10;
    localparam int UPPER_BOUND    = 20;
    localparam int LOWER_BOUND    = 460;
    localparam int SCREEN_WIDTH   = 640;
    localparam int SCREEN_HEIGHT  = 480;
    localparam int MIN_OBS_HEIGHT = 40;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [8:0] up;
        logic [8:0] down;
    } y_span_t;

    // Height is 40..167; bit 7 picks hanging from the top or standing on the floor.
    function automatic y_span_t spawn_span(input logic [7:0] r);
        y_span_t    s;
        logic [8:0] h;
        h = 9'(MIN_OBS_HEIGHT) + {2'b00, r[6:0]};
        if (r[7]) begin
            s.up   = 9'(LOWER_BOUND) - h;
            s.down = 9'(LOWER_BOUND);
        end else begin
            s.up   = 9'(UPPER_BOUND + 1);
            s.down = 9'(UPPER_BOUND + 1) + h;
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running outside reset.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // Load the seed in reset, otherwise shift one step every clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= seed;
        end else begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: per frame, scrolls every occupied slot left one slot
// per cycle, then optionally spawns a new obstacle into the lowest free slot.
//
// Handshake: frame_tick is a request sampled only while the scheduler is
// idle and not busy; busy is the "not ready" indication and stays high from
// the accepting edge until one cycle after the spawn step, so a tick that
// arrives while busy is dropped rather than queued.
module obstacle_scheduler #(
    parameter int NUM_OBS        = 10,
    parameter int SCROLL_STEP    = 4,
    parameter int SPAWN_INTERVAL = 60,
    parameter int OBS_WIDTH      = 40,
    parameter int SPAWN_X        = 600
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [1:0]              gamemode,
    output logic [NUM_OBS-1:0][9:0] obstacle_x_game_left,
    output logic [NUM_OBS-1:0][9:0] obstacle_x_game_right,
    output logic [NUM_OBS-1:0][8:0] obstacle_y_game_up,
    output logic [NUM_OBS-1:0][8:0] obstacle_y_game_down,
    output logic [NUM_OBS-1:0]      obstacle_active,
    output logic                    busy,
    output logic                    spawn_drop,
    output logic [1:0]              state_dbg
);

    import game_pkg::*;

    localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_OBS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]       STEP_X      = 10'(SCROLL_STEP);
    localparam logic [9:0]       SPAWN_LEFT  = 10'(SPAWN_X);
    localparam logic [9:0]       SPAWN_RIGHT = 10'(SPAWN_X + OBS_WIDTH);

    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] frame_cnt;
    logic             spawn_due;
    logic [15:0]      lfsr_value;
    logic             unused_lfsr_high;
    y_span_t          span;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    assign unused_lfsr_high = ^lfsr_value[15:8];
    assign span             = spawn_span(lfsr_value[7:0]);
    assign state_dbg        = state;

    // Lowest-index free slot; slots cleared during this frame's scroll already read as free.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!obstacle_active[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Frame sweep FSM: reset and INITIAL mode wipe everything; otherwise scroll then spawn.
    always_ff @(posedge clk) begin
        if (!rst_n || (gamemode == INITIAL)) begin
            state                 <= IDLE;
            idx                   <= '0;
            frame_cnt             <= '0;
            spawn_due             <= 1'b0;
            busy                  <= 1'b0;
            spawn_drop            <= 1'b0;
            obstacle_x_game_left  <= '0;
            obstacle_x_game_right <= '0;
            obstacle_y_game_up    <= '0;
            obstacle_y_game_down  <= '0;
            obstacle_active       <= '0;
        end else begin
            spawn_drop <= 1'b0;
            busy       <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_tick && !busy && (gamemode == INGAME)) begin
                        state     <= SCROLL;
                        idx       <= '0;
                        busy      <= 1'b1;
                        spawn_due <= (frame_cnt == CNT_LAST);
                        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
                    end
                end
                SCROLL: begin
                    if (obstacle_active[idx]) begin
                        if (obstacle_x_game_left[idx] < STEP_X) begin
                            obstacle_active[idx]       <= 1'b0;
                            obstacle_x_game_left[idx]  <= '0;
                            obstacle_x_game_right[idx] <= '0;
                            obstacle_y_game_up[idx]    <= '0;
                            obstacle_y_game_down[idx]  <= '0;
                        end else begin
                            obstacle_x_game_left[idx]  <= obstacle_x_game_left[idx] - STEP_X;
                            obstacle_x_game_right[idx] <= obstacle_x_game_right[idx] - STEP_X;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state <= SPAWN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SPAWN: begin
                    if (spawn_due) begin
                        if (free_found) begin
                            obstacle_active[free_idx]       <= 1'b1;
                            obstacle_x_game_left[free_idx]  <= SPAWN_LEFT;
                            obstacle_x_game_right[free_idx] <= SPAWN_RIGHT;
                            obstacle_y_game_up[free_idx]    <= span.up;
                            obstacle_y_game_down[free_idx]  <= span.down;
                        end else begin
                            spawn_drop <= 1'b1;
                        end
                    end
                    spawn_due <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler. Two instances share all stimulus: one with
// default parameters, one with a short spawn interval and an odd spawn x so
// that slots fill up, spawns get dropped, and obstacles reach left=3.
module tb_obstacle_scheduler;

    localparam int NUM_OBS = 10;
    localparam int STEP    = 4;
    localparam int WIDTH   = 40;
    localparam int INT0    = 60;
    localparam int INT1    = 4;
    localparam int X0      = 600;
    localparam int X1      = 591;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [1:0] gamemode;

    logic [NUM_OBS-1:0][9:0] o_left  [2];
    logic [NUM_OBS-1:0][9:0] o_right [2];
    logic [NUM_OBS-1:0][8:0] o_up    [2];
    logic [NUM_OBS-1:0][8:0] o_down  [2];
    logic [NUM_OBS-1:0]      o_act   [2];
    logic                    o_busy  [2];
    logic                    o_drop  [2];
    logic [1:0]              o_state [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-slot geometry in plain integers.
    int          m_left  [2][NUM_OBS];
    int          m_up    [2][NUM_OBS];
    int          m_down  [2][NUM_OBS];
    bit          m_act   [2][NUM_OBS];
    int          m_ticks [2];
    bit          m_drop  [2];
    logic [15:0] m_lfsr;
    int          drop_total [2] = '{0, 0};

    obstacle_scheduler dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x_game_left(o_left[0]), .obstacle_x_game_right(o_right[0]),
        .obstacle_y_game_up(o_up[0]), .obstacle_y_game_down(o_down[0]),
        .obstacle_active(o_act[0]), .busy(o_busy[0]), .spawn_drop(o_drop[0]),
        .state_dbg(o_state[0])
    );

    obstacle_scheduler #(.SPAWN_INTERVAL(INT1), .SPAWN_X(X1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x_game_left(o_left[1]), .obstacle_x_game_right(o_right[1]),
        .obstacle_y_game_up(o_up[1]), .obstacle_y_game_down(o_down[1]),
        .obstacle_active(o_act[1]), .busy(o_busy[1]), .spawn_drop(o_drop[1]),
        .state_dbg(o_state[1])
    );

    // clock / reset-driven model of the random source
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // running count of cycles with spawn_drop high
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) if (o_drop[d] === 1'b1) drop_total[d] <= drop_total[d] + 1;
    end

    function automatic void model_clear(input int d);
        for (int i = 0; i < NUM_OBS; i++) begin
            m_act[d][i] = 1'b0; m_left[d][i] = 0; m_up[d][i] = 0; m_down[d][i] = 0;
        end
        m_ticks[d] = 0;
        m_drop[d]  = 1'b0;
    endfunction

    // One whole frame: scroll every occupied slot, then spawn when due.
    function automatic void model_frame(input int d, input logic [15:0] r);
        int slot, h, interval, sx;
        interval = (d == 0) ? INT0 : INT1;
        sx       = (d == 0) ? X0 : X1;
        m_ticks[d]++;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (m_act[d][i]) begin
                if (m_left[d][i] < STEP) begin
                    m_act[d][i] = 1'b0; m_left[d][i] = 0; m_up[d][i] = 0; m_down[d][i] = 0;
                end else begin
                    m_left[d][i] -= STEP;
                end
            end
        end
        m_drop[d] = 1'b0;
        if (m_ticks[d] % interval == 0) begin
            slot = -1;
            for (int i = 0; i < NUM_OBS; i++) if (!m_act[d][i] && slot < 0) slot = i;
            if (slot < 0) begin
                m_drop[d] = 1'b1;
            end else begin
                h = 40 + int'(r[6:0]);
                m_act[d][slot]  = 1'b1;
                m_left[d][slot] = sx;
                m_up[d][slot]   = r[7] ? 460 - h : 21;
                m_down[d][slot] = r[7] ? 460 : 21 + h;
            end
        end
    endfunction

    // Drive one frame tick and check the sweep cycle by cycle.
    // stray: fire an extra tick mid-sweep; pause_k: switch to PAUSED at T+pause_k.
    task automatic do_frame(input bit stray, input int pause_k);
        int          k_stray, drops_at_t, exp0;
        logic [15:0] r;
        k_stray = stray ? int'($urandom_range(1, 12)) : 0;
        r = '0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_busy[d] !== 1'b1) $display("FAIL busy_rise d%0d: got %b want 1", d, o_busy[d]);
            else n_pass++;
        end
        drops_at_t = drop_total[0] + 1000 * drop_total[1];
        for (int k = 1; k <= 12; k++) begin
            if (k == k_stray) frame_tick = 1'b1;
            if (k == pause_k) gamemode = 2'b10;
            @(negedge clk); frame_tick = 1'b0;
            if (k == 1) begin
                for (int d = 0; d < 2; d++) begin
                    exp0 = (!m_act[d][0] || m_left[d][0] < STEP) ? 0 : m_left[d][0] - STEP;
                    n_checks++;
                    if (o_left[d][0] !== 10'(exp0)) $display("FAIL slot0_first d%0d: got %0d want %0d", d, o_left[d][0], exp0);
                    else n_pass++;
                end
            end
            if (k == 10) begin
                r = m_lfsr;
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (o_drop[d] !== 1'b0) $display("FAIL drop_early d%0d: got %b want 0", d, o_drop[d]);
                    else n_pass++;
                end
            end
            if (k == 11) begin
                for (int d = 0; d < 2; d++) begin
                    model_frame(d, r);
                    n_checks++;
                    if (o_drop[d] !== m_drop[d]) $display("FAIL spawn_drop d%0d: got %b want %b", d, o_drop[d], m_drop[d]);
                    else n_pass++;
                    n_checks++;
                    if (o_busy[d] !== 1'b1) $display("FAIL busy_spawn d%0d: got %b want 1", d, o_busy[d]);
                    else n_pass++;
                    for (int i = 0; i < NUM_OBS; i++) begin
                        n_checks++;
                        if (o_act[d][i] !== m_act[d][i]) $display("FAIL active d%0d s%0d: got %b want %b", d, i, o_act[d][i], m_act[d][i]);
                        else n_pass++;
                        n_checks++;
                        if (o_left[d][i] !== 10'(m_left[d][i])) $display("FAIL left d%0d s%0d: got %0d want %0d", d, i, o_left[d][i], m_left[d][i]);
                        else n_pass++;
                        n_checks++;
                        if (o_right[d][i] !== 10'(m_act[d][i] ? m_left[d][i] + WIDTH : 0))
                            $display("FAIL right d%0d s%0d: got %0d want %0d", d, i, o_right[d][i], m_act[d][i] ? m_left[d][i] + WIDTH : 0);
                        else n_pass++;
                        n_checks++;
                        if (o_up[d][i] !== 9'(m_up[d][i])) $display("FAIL up d%0d s%0d: got %0d want %0d", d, i, o_up[d][i], m_up[d][i]);
                        else n_pass++;
                        n_checks++;
                        if (o_down[d][i] !== 9'(m_down[d][i])) $display("FAIL down d%0d s%0d: got %0d want %0d", d, i, o_down[d][i], m_down[d][i]);
                        else n_pass++;
                    end
                end
            end
            if (k == 12) begin
                for (int d = 0; d < 2; d++) begin
                    n_checks++;
                    if (o_busy[d] !== 1'b0) $display("FAIL busy_fall d%0d: got %b want 0", d, o_busy[d]);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if ((drop_total[0] + 1000 * drop_total[1]) - drops_at_t !== int'(m_drop[0]) + 1000 * int'(m_drop[1]))
            $display("FAIL drop_pulse_count: got %0d want %0d",
                     (drop_total[0] + 1000 * drop_total[1]) - drops_at_t, int'(m_drop[0]) + 1000 * int'(m_drop[1]));
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b0; gamemode = 2'b00;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            n_checks++;
            if ({o_left[d], o_right[d], o_up[d], o_down[d]} !== '0) $display("FAIL reset_slots d%0d: got nonzero want 0", d);
            else n_pass++;
            n_checks++;
            if ({o_act[d], o_busy[d], o_drop[d], o_state[d]} !== '0)
                $display("FAIL reset_flags d%0d: got %b want 0", d, {o_act[d], o_busy[d], o_drop[d], o_state[d]});
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frames(input int n);
        gamemode = 2'b01;
        for (int f = 0; f < n; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_frame(1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_pause();
        gamemode = 2'b01;
        do_frame(1'b0, 3);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
            repeat (3) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_busy[d] !== 1'b0) $display("FAIL paused_busy d%0d: got %b want 0", d, o_busy[d]);
                else n_pass++;
                for (int i = 0; i < NUM_OBS; i++) begin
                    n_checks++;
                    if (o_act[d][i] !== m_act[d][i] || o_left[d][i] !== 10'(m_left[d][i]))
                        $display("FAIL paused_slot d%0d s%0d: got %b/%0d want %b/%0d", d, i, o_act[d][i], o_left[d][i], m_act[d][i], m_left[d][i]);
                    else n_pass++;
                end
            end
        end
        gamemode = 2'b01;
    endtask

    task automatic test_abort();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        gamemode = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            n_checks++;
            if ({o_left[d], o_right[d], o_up[d], o_down[d], o_act[d], o_busy[d]} !== '0)
                $display("FAIL abort_clear d%0d: got act=%b busy=%b want 0", d, o_act[d], o_busy[d]);
            else n_pass++;
        end
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({o_act[d], o_busy[d]} !== '0) $display("FAIL abort_hold d%0d: got %b want 0", d, {o_act[d], o_busy[d]});
            else n_pass++;
        end
        gamemode = 2'b01;
    endtask

    task automatic test_reset_mid_sweep();
        gamemode = 2'b01;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            n_checks++;
            if ({o_left[d], o_right[d], o_up[d], o_down[d], o_act[d], o_busy[d], o_drop[d]} !== '0)
                $display("FAIL reset_mid d%0d: got act=%b busy=%b want 0", d, o_act[d], o_busy[d]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frames(59);
        test_frames(1);
        test_frames(200);
        test_pause();
        test_frames(5);
        test_abort();
        test_frames(62);
        test_reset_mid_sweep();
        test_frames(61);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter NUM_OBS, default 10, number of obstacle slots.
REQ-002 Parameter SCROLL_STEP, default 4, pixels moved left per frame.
REQ-003 Parameter SPAWN_INTERVAL, default 60, frames between spawn attempts.
REQ-004 Parameter OBS_WIDTH, default 40, obstacle width in pixels.
REQ-005 Parameter SPAWN_X, default 600, left edge of a newly spawned obstacle.
REQ-006 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 Port rst_n  input  1  synchronous, active-low reset.
REQ-008 Port frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-009 Port gamemode  input  2  00 initial, 01 in-game, 10 paused, 11 ended.
REQ-010 Port obstacle_x_game_left / obstacle_x_game_right  output  [NUM_OBS][10]  per-slot left (inclusive) and right (exclusive) x.
REQ-011 Port obstacle_y_game_up / obstacle_y_game_down  output  [NUM_OBS][9]  per-slot top (inclusive) and bottom (exclusive) y.
REQ-012 Port obstacle_active  output  [NUM_OBS]  slot-occupied flags.
REQ-013 Port busy  output  1  high while a frame update is in progress.
REQ-014 Port spawn_drop  output  1  one-cycle pulse when a due spawn finds no free slot.

Function
REQ-015 States IDLE, SCROLL, SPAWN; all outputs registered.
REQ-016 Inactive slot SHALL drive left=right=0 and up=down=0, giving an empty rectangle.
REQ-017 IDLE -> SCROLL on frame_tick with gamemode=01; the slot index starts at 0.
REQ-018 SCROLL handles one slot per cycle: if active and left < SCROLL_STEP, clear the slot; else left -= SCROLL_STEP and right -= SCROLL_STEP.
REQ-019 SCROLL -> SPAWN after slot NUM_OBS-1; SPAWN -> IDLE after one cycle.
REQ-020 Latency: with tick at cycle T, slot i updates at T+1+i, the spawn write occurs at T+NUM_OBS+1, and busy falls at T+NUM_OBS+2.
REQ-021 A frame counter increments once per SCROLL entry; the spawn is due when the counter equals SPAWN_INTERVAL-1, and the counter then wraps to 0.
REQ-022 Due spawn writes the lowest-index inactive slot, including a slot freed in the same frame: left=SPAWN_X, right=SPAWN_X+OBS_WIDTH.
REQ-023 Spawn height h = 40 + lfsr[6:0] (range 40..167); lfsr[7]=0 gives up=21, down=21+h; lfsr[7]=1 gives up=460-h, down=460.
REQ-024 Due spawn with all slots active asserts spawn_drop for the SPAWN cycle only; the counter still wraps.
REQ-025 The 16-bit LFSR uses Fibonacci taps 16,14,13,11 and advances every clock outside reset.
REQ-026 frame_tick while busy is ignored.
REQ-027 gamemode 10 or 11: no new sweep starts; a sweep already in progress completes, so frame updates are atomic.
REQ-028 gamemode 00: the next cycle clears all slots and the counter, aborts any sweep, returns to IDLE, and holds that state while 00.

Reset
REQ-029 rst_n low at a clock edge: state IDLE, all slot outputs 0, obstacle_active 0, busy 0, spawn_drop 0, counter 0, LFSR 16'hACE1.
REQ-030 Reset mid-sweep takes effect on the same edge; no partial slot write survives.

Structure
REQ-031 Shared package game_pkg holds the gamemode enum (INITIAL, INGAME, PAUSED, ENDED), NUM_OBS, UPPER_BOUND=20, LOWER_BOUND=460 and the screen dimensions 640x480.
REQ-032 The LFSR is a sub-module lfsr16 (ports: clk, rst_n, seed, value[15:0]); everything else is flat.

Verification
REQ-033 Reset, then gamemode=01, 59 ticks -> no slot active, spawn_drop never asserted.
REQ-034 60th tick at cycle T -> slot 0 active at T+11 with left=600, right=640, and up/down matching REQ-023 for the lfsr value sampled that cycle.
REQ-035 Slot at left=3, one tick -> slot cleared (outputs all 0, active=0); slot at left=4 -> left=0, right=40, stays active.
REQ-036 All 10 slots active and a spawn due -> spawn_drop high exactly one cycle at T+11, slots unchanged except scroll.
REQ-037 Tick at T, gamemode 01->10 at T+3 -> sweep finishes and busy falls at T+12; further ticks while 10 change nothing.
REQ-038 gamemode->00 at T+5 mid-sweep -> all slots 0 and busy 0 at T+6; rst_n low mid-sweep -> REQ-029 values on the next edge.
